spi_mem_reader: RTL
===================

# spi_mem_reader

Read-only SPI NOR flash controller that fetches 32-bit instruction/data words for the SotaSoC core over the Tiny Tapeout `uio` pins. It sits directly between the core's fetch/load request port and the `tt_um_SotaSoC` top-level pin mapping: it consumes word-read requests and drives the flash chip-select, clock and MOSI out through `uio_out`/`uio_oe`, sampling MISO from `uio_in`. It issues standard 0x03 READ commands in SPI mode 0.

## Interface
- `CLK_DIV`, 1: SCK half-period in `clk` cycles (≥1); one SPI bit = 2·CLK_DIV cycles.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  read request.
- `req_ready`  out  1  high only in IDLE (or SEQ_WAIT); transfer on `req_valid && req_ready`.
- `req_addr`  in  24  byte address; bits [1:0] ignored (treated as 0).
- `rsp_valid`  out  1  one-cycle pulse, data valid.
- `rsp_data`  out  32  fetched word, little-endian.
- `spi_cs_n`  out  1  flash chip select, active low.
- `spi_sck`  out  1  SPI clock, idle low.
- `spi_mosi`  out  1  serial data to flash.
- `spi_miso`  in  1  serial data from flash.

## Operation
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0; state IDLE. Reset asserted mid-transfer forces these values immediately (async); no partial response is ever emitted.
- States: IDLE → CMD (8 bits, 0x03) → ADDR (24 bits, {req_addr[23:2],2'b00}) → DATA (32 bits) → DONE → DESEL → IDLE.
- All bits MSB-first. MOSI changes while SCK low; MISO sampled on the `clk` edge ending each SCK-high phase.
- Flash returns bytes in ascending address order; byte at addr lands in `rsp_data[7:0]`, addr+3 in `[31:24]`.
- DONE: `rsp_valid` pulses one cycle with `rsp_data`; `rsp_data` holds until next response.
- DESEL: `spi_cs_n`=1 for exactly 2 cycles (tSHSL), then IDLE. `req_ready`=0 in CMD/ADDR/DATA/DONE/DESEL.
- `req_valid` while not ready is ignored; request need not be held beyond acceptance (address latched on accept).

## Timing
- Accept at edge 0; cycle 1: `spi_cs_n`=0, `spi_sck`=0, `spi_mosi`=1'b0 (bit 7 of 0x03).
- Full transfer: 64 bits; `rsp_valid` high in cycle 1 + 128·CLK_DIV (CLK_DIV=1 → cycle 129).
- Back-to-back (non-sequential): next accept no earlier than 3 cycles after `rsp_valid`.
- `spi_sck` toggles every CLK_DIV cycles during CMD/ADDR/DATA only; low in all other states; ends low before CS rises.

## Configuration
- `SPI_SEQ_READ_EN` defined: after DONE go to SEQ_WAIT with `spi_cs_n` kept low and `req_ready`=1. A request whose word address equals previous+4 (24-bit wrap, 0xFFFFFC → 0x000000 counts) skips CMD/ADDR and goes straight to DATA: `rsp_valid` in cycle 1 + 64·CLK_DIV. Any other address: DESEL (2 cycles CS high) then full transfer from CMD, `rsp_valid` in cycle 3 + 1 + 128·CLK_DIV.
- Undefined: SEQ_WAIT absent; every request is a full 64-bit transfer; DONE always goes to DESEL.

## Structure
- Package `spi_mem_pkg`: state enum, `SPI_CMD_READ`=8'h03, bit counts (8/24/32), `DESEL_CYCLES`=2.
- One sub-module `spi_sck_gen`: CLK_DIV counter producing SCK level plus one-cycle `shift_stb` (falling) and `sample_stb` (end of high) strobes, enabled by the FSM.
- Single shift register (64-bit out, 32-bit in) and a 6-bit bit counter in the top FSM.

## Test plan
- Reset then idle: `spi_cs_n`=1, `spi_sck`=0, `req_ready`=1, `rsp_valid` never asserts for 200 cycles.
- CLK_DIV=1, read 0x000100, flash model bytes 0x13,0x05,0x00,0x00 → MOSI stream 0x03,0x00,0x01,0x00; `rsp_data`=0x00000513 in cycle 129; CS high 2 cycles after.
- `req_addr`=0x000103 → address phase shows 0x000100; CLK_DIV=3 → `rsp_valid` in cycle 385, SCK period 6 cycles.
- `SPI_SEQ_READ_EN`: reads 0x000000 then 0x000004 → second response 65 cycles after accept, no CMD/ADDR bits, CS never rises; then 0x000010 → CS high 2 cycles, full transfer.
- `rst_n` pulsed low during ADDR phase → outputs return to reset values same cycle, no `rsp_valid`; next request completes normally.
- `req_valid` held during transfer with changing `req_addr` → ignored until `req_ready`; response matches the latched address only.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared state type, command and frame helpers for spi_mem_reader.
// SEQ_WAIT exists only when SPI_SEQ_READ_EN is defined.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE,
    DESEL
`ifdef SPI_SEQ_READ_EN
    , SEQ_WAIT
`endif
  } state_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;

  localparam int CMD_BITS     = 8;
  localparam int ADDR_BITS    = 24;
  localparam int DATA_BITS    = 32;
  localparam int DESEL_CYCLES = 2;

  // Outgoing frame: command, word-aligned address, then 32 dummy bits.
  function automatic logic [63:0] tx_frame(
    input logic [21:0] wa
  );
    return {SPI_CMD_READ, wa, 2'b00, 32'h0};
  endfunction

  function automatic logic [31:0] bswap32(
    input logic [31:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: SCK divider for spi_mem_reader, mode 0 (idle low).
// Strobes fire on the clk edge that ends each SCK-high phase.
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic shift_stb,
  output logic sample_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap       = en && (cnt == CW'(CLK_DIV - 1));
  assign shift_stb  = wrap && sck;
  assign sample_stb = wrap && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_mem_reader.sv
// spi_mem_reader: read-only SPI NOR word fetch, 0x03 READ in SPI mode 0.
// Define SPI_SEQ_READ_EN to hold CS low and stream sequential words.
module spi_mem_reader #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);
  import spi_mem_pkg::*;

  state_t      state;
  logic [63:0] sr;
  logic [5:0]  bit_cnt;
  logic [1:0]  dcnt;
  logic        sck_en;
  logic        shift_stb;
  logic        sample_stb;
  logic        last_bit;
  logic [31:0] rx_word;
  logic        unused_addr;
`ifdef SPI_SEQ_READ_EN
  logic [21:0] wa;
  logic        pend;
`endif

  assign unused_addr = ^req_addr[1:0];
  assign sck_en   = (state == CMD) || (state == ADDR) || (state == DATA);
  assign spi_mosi = sr[63];
  assign rx_word  = {sr[30:0], spi_miso};

  always_comb begin
    last_bit = 1'b0;
    unique case (1'b1)
      state == CMD:  last_bit = bit_cnt == 6'(CMD_BITS - 1);
      state == ADDR: last_bit = bit_cnt == 6'(ADDR_BITS - 1);
      state == DATA: last_bit = bit_cnt == 6'(DATA_BITS - 1);
      default: ;
    endcase
  end

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (sck_en),
    .sck        (spi_sck),
    .shift_stb  (shift_stb),
    .sample_stb (sample_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      dcnt      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      spi_cs_n  <= 1'b1;
`ifdef SPI_SEQ_READ_EN
      wa        <= '0;
      pend      <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= CMD;
            sr        <= tx_frame(req_addr[23:2]);
            bit_cnt   <= '0;
            spi_cs_n  <= 1'b0;
            req_ready <= 1'b0;
`ifdef SPI_SEQ_READ_EN
            wa        <= req_addr[23:2];
`endif
          end
        end
        CMD, ADDR, DATA: begin
          if (shift_stb) sr <= {sr[62:0], spi_miso};
          if (sample_stb) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + 6'd1;
            if (last_bit) begin
              if (state == CMD) begin
                state <= ADDR;
              end else if (state == ADDR) begin
                state <= DATA;
              end else begin
                state     <= DONE;
                rsp_valid <= 1'b1;
                rsp_data  <= bswap32(rx_word);
              end
            end
          end
        end
        DONE: begin
          sr <= '0;
`ifdef SPI_SEQ_READ_EN
          state     <= SEQ_WAIT;
          req_ready <= 1'b1;
`else
          state    <= DESEL;
          spi_cs_n <= 1'b1;
          dcnt     <= '0;
`endif
        end
        DESEL: begin
          spi_cs_n <= 1'b1;
          dcnt     <= dcnt + 2'd1;
          if (dcnt == 2'(DESEL_CYCLES - 1)) begin
`ifdef SPI_SEQ_READ_EN
            if (pend) begin
              state    <= CMD;
              sr       <= tx_frame(wa);
              bit_cnt  <= '0;
              spi_cs_n <= 1'b0;
              pend     <= 1'b0;
            end else begin
              state     <= IDLE;
              req_ready <= 1'b1;
            end
`else
            state     <= IDLE;
            req_ready <= 1'b1;
`endif
          end
        end
`ifdef SPI_SEQ_READ_EN
        SEQ_WAIT: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wa        <= req_addr[23:2];
            if (req_addr[23:2] == wa + 22'd1) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // First DESEL cycle keeps CS low so CS is high exactly two cycles.
              state <= DESEL;
              dcnt  <= '1;
              pend  <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
